// File: rtl/ws2812b_pkg.sv
// Shared definitions for the WS2812B serial transmitter and its testbench.
// Holds default bit timings (64 MHz clock), the FSM state encoding, the
// pixel payload layout and a helper that sizes the cycle counter.
package ws2812b_pkg;

  // Default timings in clk cycles at 64 MHz.
  localparam int unsigned T0H_CYC_DEF   = 26;    // 0.40 us high for a '0'
  localparam int unsigned T1H_CYC_DEF   = 51;    // 0.80 us high for a '1'
  localparam int unsigned BIT_CYC_DEF   = 80;    // 1.25 us per bit
  localparam int unsigned LATCH_CYC_DEF = 5120;  // 80 us latch gap

  localparam int unsigned PIX_W     = 24;
  localparam int unsigned BIT_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  // One pixel in wire order: green first, blue last.
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;

  // Counter width able to hold max(bit_cyc, latch_cyc) - 1.
  function automatic int unsigned cnt_width(input int unsigned bit_cyc,
                                            input int unsigned latch_cyc);
    int unsigned m;
    m = (bit_cyc > latch_cyc) ? bit_cyc : latch_cyc;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/ws2812b_tx_if.sv
// Pixel handshake between a frame source and the WS2812B transmitter.
//   data_in : pixel {G,R,B}, captured on accept
//   valid   : source requests transmission of data_in
//   latch   : append a latch gap after this pixel, captured on accept
//   ready   : transmitter can accept a pixel this cycle
// master = pixel source, slave = transmitter.
interface ws2812b_tx_if;
  import ws2812b_pkg::*;

  pixel_t data_in;
  logic   valid;
  logic   latch;
  logic   ready;

  modport master (output data_in, output valid, output latch, input ready);
  modport slave  (input data_in, input valid, input latch, output ready);

endinterface

// File: rtl/ws2812b_tx.sv
// WS2812B single-wire LED transmitter.
// Serialises one 24-bit pixel MSB first as fixed-period bits whose high time
// encodes the bit value, optionally followed by a long low latch gap.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : pixel handshake (slave side), ready high only while idle
//   led   : registered serial line to the strip
module ws2812b_tx
  import ws2812b_pkg::*;
#(
  parameter int unsigned T0H_CYC   = T0H_CYC_DEF,
  parameter int unsigned T1H_CYC   = T1H_CYC_DEF,
  parameter int unsigned BIT_CYC   = BIT_CYC_DEF,
  parameter int unsigned LATCH_CYC = LATCH_CYC_DEF
) (
  input  logic         clk,
  input  logic         reset,
  ws2812b_tx_if.slave  bus,
  output logic         led
);

  localparam int unsigned CNT_W = cnt_width(BIT_CYC, LATCH_CYC);

  // Reject timings that cannot form a valid bit.
  if (!((T0H_CYC > 0) && (T0H_CYC < T1H_CYC) && (T1H_CYC < BIT_CYC) &&
        (LATCH_CYC > 0))) begin : g_param_err
    $error("ws2812b_tx: need 0 < T0H_CYC < T1H_CYC < BIT_CYC and LATCH_CYC > 0");
  end

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0]   idx_q, idx_d;
  pixel_t                 pix_q, pix_d;
  logic                   lat_q, lat_d;
  logic                   ready_q, ready_d;
  logic                   led_q, led_d;

  logic                   accept_c;
  logic [PIX_W-1:0]       pix_vec_c;
  logic                   cur_bit_c;
  logic [CNT_W-1:0]       high_last_c;
  logic [CNT_W-1:0]       low_last_c;

  // ready is high exactly in IDLE, so this is the accept condition.
  assign accept_c  = bus.valid & ready_q;
  assign pix_vec_c = pix_q;
  assign cur_bit_c = pix_vec_c[idx_q];

  // Last counter value of the high and low phase for the current bit;
  // the two phases always add up to BIT_CYC.
  assign high_last_c = cur_bit_c ? CNT_W'(T1H_CYC - 1) : CNT_W'(T0H_CYC - 1);
  assign low_last_c  = cur_bit_c ? CNT_W'(BIT_CYC - T1H_CYC - 1)
                                 : CNT_W'(BIT_CYC - T0H_CYC - 1);

  // Next-state, counter, capture and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pix_d   = pix_q;
    lat_d   = lat_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          idx_d   = BIT_IDX_W'(PIX_W - 1);
          pix_d   = bus.data_in;
          lat_d   = bus.latch;
        end
      end
      ST_HIGH: begin
        if (cnt_q == high_last_c) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOW: begin
        if (cnt_q == low_last_c) begin
          cnt_d = '0;
          if (idx_q == '0) begin
            state_d = lat_q ? ST_LATCH : ST_IDLE;
          end else begin
            idx_d   = idx_q - BIT_IDX_W'(1);
            state_d = ST_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LATCH: begin
        if (cnt_q == CNT_W'(LATCH_CYC - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // led follows the state one cycle later, so it never glitches.
    led_d   = (state_q == ST_HIGH);
    ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= BIT_IDX_W'(PIX_W - 1);
      pix_q   <= '0;
      lat_q   <= 1'b0;
      ready_q <= 1'b1;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pix_q   <= pix_d;
      lat_q   <= lat_d;
      ready_q <= ready_d;
      led_q   <= led_d;
    end
  end

  assign bus.ready = ready_q;
  assign led       = led_q;

endmodule

// File: tb/tb_ws2812b_tx.sv
// Testbench for ws2812b_tx: the driver pushes the expected pulse train of
// every accepted pixel into a queue; an independent monitor measures high
// and low run lengths on led and checks them against the queue.
module tb_ws2812b_tx;
  import ws2812b_pkg::*;

  localparam int T0H     = int'(T0H_CYC_DEF);
  localparam int T1H     = int'(T1H_CYC_DEF);
  localparam int BITC    = int'(BIT_CYC_DEF);
  localparam int LATC    = int'(LATCH_CYC_DEF);
  localparam int PIXC    = 24 * BITC;
  localparam int OPEN_HI = 1000000;

  logic clk = 1'b0;
  logic reset;
  logic led;

  ws2812b_tx_if bus();

  ws2812b_tx #(
    .T0H_CYC   (T0H_CYC_DEF),
    .T1H_CYC   (T1H_CYC_DEF),
    .BIT_CYC   (BIT_CYC_DEF),
    .LATCH_CYC (LATCH_CYC_DEF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .led   (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    int high;
    int low_min;
    int low_max;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act,
                             input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // Reference model: each bit is a pulse of T1H or T0H, then low for the
  // rest of the bit period. The last bit's low also spans any latch gap and
  // the idle time before the next pixel (1 cycle when sent back to back).
  task automatic push_pixel(input logic [23:0] px, input logic lat, input bit b2b);
    exp_t e;
    logic b;
    for (int i = 0; i < 24; i++) begin
      b         = px[23 - i];
      e.high    = b ? T1H : T0H;
      e.low_min = BITC - e.high;
      e.low_max = e.low_min;
      if (i == 23) begin
        if (lat) begin
          e.low_min += LATC;
          e.low_max += LATC;
        end
        if (b2b) begin
          e.low_min += 1;
          e.low_max = e.low_min + 1;
        end else begin
          e.low_max = OPEN_HI;
        end
      end
      exp_q.push_back(e);
    end
  endtask

  // Monitor: measure run lengths of led, sampled on the falling clock edge.
  int   hi_cnt = 0;
  int   lo_cnt = 0;
  logic prev_led = 1'b0;
  bit   have_cur = 1'b0;
  exp_t cur;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        have_cur = 1'b0;
        prev_led = 1'b0;
        hi_cnt   = 0;
        lo_cnt   = 0;
      end else begin
        if (led && !prev_led) begin
          if (have_cur) check_range("bit_low", lo_cnt, cur.low_min, cur.low_max);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            have_cur = 1'b0;
            $display("FAIL pulse_expected: got a pulse, expected none (t=%0t)", $time);
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
          end
          hi_cnt = 1;
        end else if (led) begin
          hi_cnt++;
        end else if (prev_led) begin
          if (have_cur) check("bit_high", hi_cnt, cur.high);
          lo_cnt = 1;
        end else begin
          lo_cnt++;
        end
        prev_led = led;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pixel as soon as ready, hold valid for 'hold' cycles (extra
  // cycles carry junk that must be ignored). t_out counts cycles after accept.
  task automatic start_px(input logic [23:0] px, input logic lat, input int hold,
                          input bit b2b, output int t_out);
    int n;
    n = 0;
    t_out = 0;
    while (!bus.ready && n < 10000) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.ready) begin
      errors++;
      $display("FAIL ready_wait: got ready=0, expected ready=1 within 10000 cycles");
      return;
    end
    push_pixel(px, lat, b2b);
    bus.data_in = px;
    bus.latch   = lat;
    bus.valid   = 1'b1;
    tick();
    check("ready_drop", int'(bus.ready), 0);
    for (int i = 1; i < hold; i++) begin
      bus.data_in = 24'($urandom);
      bus.latch   = 1'($urandom_range(0, 1));
      tick();
      t_out++;
      check("ready_hold", int'(bus.ready), 0);
    end
    bus.valid   = 1'b0;
    bus.data_in = 24'($urandom);
    bus.latch   = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [23:0] px, input logic lat, input int hold, input bit b2b);
    int t;
    start_px(px, lat, hold, b2b, t);
    while (!bus.ready && t < 9000) begin
      tick();
      t++;
    end
    check("ready_rise", t, PIXC + (lat ? LATC : 0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish by t=1000000");
    $fatal(1, "timeout");
  end

  initial begin
    int  t;
    bit  lat;
    bit  b2b;

    bus.data_in = '0;
    bus.valid   = 1'b0;
    bus.latch   = 1'b0;
    reset       = 1'b1;
    repeat (3) begin
      tick();
      check("rst_led", int'(led), 0);
      check("rst_ready", int'(bus.ready), 1);
    end
    reset = 1'b0;

    // All ones then zeros, latch-terminated pattern, then a held valid.
    send(24'hFF0000, 1'b0, 1, 1'b1);
    send(24'h00AA55, 1'b1, 1, 1'b1);
    send(24'h5A3C81, 1'b0, 3, 1'b1);

    // Abort mid-pixel with reset.
    start_px(24'($urandom), 1'b0, 1, 1'b0, t);
    while (t < 500) begin
      tick();
      t++;
    end
    reset = 1'b1;
    #1;
    check("abort_led", int'(led), 0);
    check("abort_ready", int'(bus.ready), 1);
    repeat (2) begin
      tick();
      check("abort_hold_led", int'(led), 0);
    end
    reset = 1'b0;
    check("release_ready", int'(bus.ready), 1);
    send(24'h000001, 1'b0, 1, 1'b1);

    // Back-to-back pair.
    send(24'hC3_0F_F0, 1'b0, 1, 1'b1);
    send(24'h81_7E_18, 1'b0, 1, 1'b0);
    repeat (10) tick();

    // Randomised pixels, latches and gaps.
    for (int k = 0; k < 8; k++) begin
      lat = ($urandom_range(0, 3) == 0);
      b2b = (k < 7) && ($urandom_range(0, 1) == 1);
      send(24'($urandom), lat, int'($urandom_range(1, 3)), b2b);
      if (!b2b) repeat (int'($urandom_range(3, 40))) tick();
    end

    repeat (200) tick();
    if (have_cur) check_range("final_low", lo_cnt, cur.low_min, OPEN_HI);
    check("bits_left", exp_q.size(), 0);
    check("idle_led", int'(led), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812b_tx.md
WS2812B_TX -- requirements
Module: ws2812b_tx

Interface
REQ-001 Parameter T0H_CYC, default 26, SHALL set high time of a '0' bit in clk cycles (0.40 us at 64 MHz).
REQ-002 Parameter T1H_CYC, default 51, SHALL set high time of a '1' bit in clk cycles (0.80 us).
REQ-003 Parameter BIT_CYC, default 80, SHALL set the total period of one bit in clk cycles (1.25 us).
REQ-004 Parameter LATCH_CYC, default 5120, SHALL set the low time of the latch (reset) gap in clk cycles (80 us).
REQ-005 Port clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1, SHALL be the reset: asynchronous and active-high.
REQ-007 Port data_in, input, 24, SHALL carry one pixel as {G,R,B}; sampled only on accept.
REQ-008 Port valid, input, 1, SHALL request transmission of data_in.
REQ-009 Port latch, input, 1, SHALL request a latch gap after this pixel; sampled only on accept.
REQ-010 Port ready, output, 1, SHALL be high exactly when a new pixel can be accepted.
REQ-011 Port led, output, 1, SHALL be the registered serial line to the strip.

Function
REQ-012 Accept SHALL occur on a rising edge where valid=1 and ready=1; valid while ready=0 SHALL be ignored without side effects.
REQ-013 On accept, data_in and latch SHALL be captured into internal registers, and ready SHALL be 0 from the next cycle.
REQ-014 States SHALL be IDLE, HIGH, LOW, LATCH; ready=1 only in IDLE.
REQ-015 IDLE->HIGH on accept; bit index set to 23, cycle counter cleared.
REQ-016 HIGH SHALL drive led=1 for T1H_CYC cycles if current bit is 1, else T0H_CYC cycles, then go to LOW.
REQ-017 LOW SHALL drive led=0 for BIT_CYC minus the HIGH time, so every bit is exactly BIT_CYC cycles.
REQ-018 Bits SHALL be sent MSB first: data_in[23] first, data_in[0] last (G7..G0, R7..R0, B7..B0).
REQ-019 After LOW of bit 0: to LATCH if captured latch=1, else to IDLE; a pixel therefore occupies 24*BIT_CYC = 1920 cycles.
REQ-020 LATCH SHALL hold led=0 for LATCH_CYC cycles, then go to IDLE.
REQ-021 In IDLE led SHALL be 0; the IDLE time between back-to-back pixels SHALL only extend the last bit's low time.
REQ-022 The led edge SHALL appear in the cycle after the state transition that causes it (registered output, no glitches).
REQ-023 Cycle counter SHALL be wide enough for max(BIT_CYC, LATCH_CYC)-1 (13 bits at defaults) and SHALL never wrap within a state.
REQ-024 Parameters SHALL satisfy 0<T0H_CYC<T1H_CYC<BIT_CYC; violation SHALL be flagged at elaboration.

Reset
REQ-025 While reset=1: state=IDLE, led=0, ready=1, counter=0, bit index=23, captured data/latch=0.
REQ-026 Reset asserted mid-pixel or mid-latch SHALL abort immediately; no partial bit resumes after release.
REQ-027 The first accept SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-028 Default timing constants and the state encoding SHALL live in shared package ws2812b_pkg for use by the driver and testbench.
REQ-029 No sub-module SHALL be used; the block is one FSM with a counter and a 24-bit shift/index register.

Verification
REQ-030 Send 0xFF0000, latch=0 -> 8 pulses of 51 high/29 low, then 16 pulses of 26 high/54 low; ready back to 1 at cycle 1920 after accept.
REQ-031 Send 0x00AA55 with latch=1 -> bit pattern 00000000 10101010 01010101, then led low 5120 cycles; ready=1 only after that.
REQ-032 Hold valid=1 for 3 cycles with different data -> only the first word is sent; ready=0 from cycle 1 after accept.
REQ-033 Assert reset at cycle 500 of a pixel -> led=0 and ready=1 immediately; new pixel 0x000001 after release is sent completely and correctly.
REQ-034 Back-to-back pixels, valid re-asserted 1 cycle after ready rises -> 48 bits; all bit periods 80 cycles except the inter-pixel bit, extended by 1-2 cycles.
